// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider with stall/done handshake for the SDIV/UDIV path.
// Signed operands are divided as magnitudes; signs are reapplied when the result is registered.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_sel,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q;        // dividend magnitude, shifted out MSB-first; quotient bits shift in at LSB
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    count;
  logic             neg_q, neg_r;

  logic             launch, last_step, q_bit;
  logic [WIDTH-1:0] dividend_abs, divisor_abs, a_step;
  logic [WIDTH:0]   rem_shift, rem_step;

  // One restoring step per BUSY cycle, plus operand magnitudes for the launch.
  always_comb begin
    launch       = (state == IDLE) && start && !abort;
    dividend_abs = (div_sel && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (div_sel && divisor[WIDTH-1])  ? -divisor  : divisor;
    rem_shift    = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
    q_bit        = (rem_shift >= {1'b0, b_q});
    rem_step     = q_bit ? (rem_shift - {1'b0, b_q}) : rem_shift;
    a_step       = {a_q[WIDTH-2:0], q_bit};
    last_step    = (state == BUSY) && (count == CW'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (launch) state_nxt = (divisor == '0) ? DONE : BUSY;
      BUSY: if (count == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
    stall = launch || (state == BUSY);
    done  = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (launch) begin
        if (divisor == '0) begin
          quotient    <= '0;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          a_q   <= dividend_abs;
          b_q   <= divisor_abs;
          rem_q <= '0;
          count <= CW'(WIDTH);
          neg_q <= div_sel & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r <= div_sel & dividend[WIDTH-1];
        end
      end
      if ((state == BUSY) && !abort) begin
        a_q   <= a_step;
        rem_q <= rem_step;
        count <= count - CW'(1);
        // Final step: results are registered directly from the last step's values.
        if (last_step) begin
          quotient    <= neg_q ? -a_step : a_step;
          remainder   <= neg_r ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule
